// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM control path: debounce FSM states,
// duty level limits and the PWM period that the duty selector must track.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } debounce_state_t;

    localparam logic [1:0] DUTY_MAX   = 2'd3;
    localparam logic [1:0] DUTY_MIN   = 2'd0;
    localparam int         PWM_PERIOD = 8;

    // Saturating level step; simultaneous up and down presses cancel out.
    function automatic logic [1:0] step_level(input logic [1:0] level,
                                              input logic       up,
                                              input logic       down);
        logic [1:0] next_level;
        next_level = level;
        if (up && !down && level != DUTY_MAX) begin
            next_level = level + 2'd1;
        end else if (down && !up && level != DUTY_MIN) begin
            next_level = level - 2'd1;
        end
        return next_level;
    endfunction

endpackage : pwm_ctrl_pkg

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus press/release debounce FSM for one raw button.
// Emits a single-cycle press strobe per accepted press; holding never repeats.
module button_debouncer
    import pwm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             btn_sync;
    debounce_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sync_d   = {sync_q[0], btn_raw};
    assign btn_sync = sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, like real hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b00;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high during release returns silently to PRESSED.
                if (btn_sync) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule : button_debouncer

// File: rtl/duty_cycle_selector.sv
// Turns debounced up/down presses into a saturating 2-bit duty level that is
// committed only at a PWM period boundary, so the comparator never sees a mid-period change.
module duty_cycle_selector
    import pwm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PERIOD          = PWM_PERIOD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] duty_cycle,
    output logic       duty_update
);

    localparam int              PH_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);

    logic            up_press;
    logic            down_press;
    logic [1:0]      pending_q, pending_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [1:0]      duty_q, duty_d;
    logic            update_q, update_d;
    logic            commit;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_up_debouncer (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_up),
        .press   (up_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_down_debouncer (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_down),
        .press   (down_press)
    );

    // The phase counter free-runs from reset, staying in lockstep with the PWM counter.
    always_comb begin
        commit    = (phase_q == PH_LAST);
        phase_d   = commit ? '0 : phase_q + 1'b1;
        pending_d = step_level(pending_q, up_press, down_press);
        duty_d    = commit ? pending_q : duty_q;
        update_d  = commit && (pending_q != duty_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= DUTY_MIN;
            phase_q   <= '0;
            duty_q    <= DUTY_MIN;
            update_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            phase_q   <= phase_d;
            duty_q    <= duty_d;
            update_q  <= update_d;
        end
    end

    assign duty_cycle  = duty_q;
    assign duty_update = update_q;

endmodule : duty_cycle_selector

// File: tb/tb_duty_cycle_selector.sv
// Scoreboard bench for duty_cycle_selector: each press pushes its expected
// committed level and commit cycle; a negedge monitor pops on every duty_update.
module tb_duty_cycle_selector;
    import pwm_ctrl_pkg::*;

    localparam int DEB = 4;
    localparam int PER = 8;

    typedef struct {
        logic [1:0] duty;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [1:0] duty_cycle;
    logic       duty_update;

    int         checks = 0;
    int         errors = 0;
    int         tb_cyc;
    int         upd_count = 0;
    int         last_upd_cyc = -1;
    logic [1:0] last_duty = 2'd0;
    logic [1:0] model_level = 2'd0;
    exp_t       sb_q[$];

    always #5 clk = ~clk;

    duty_cycle_selector #(
        .DEBOUNCE_CYCLES (DEB),
        .PERIOD          (PER)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .duty_cycle  (duty_cycle),
        .duty_update (duty_update)
    );

    // Edges since reset release; the PWM phase is tb_cyc mod PER.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    // Monitor: every update must match the scoreboard head; otherwise the output holds.
    always @(negedge clk) begin
        if (reset) begin
            last_duty = 2'd0;
        end else if (duty_update === 1'b1) begin
            exp_t e;
            upd_count++;
            last_upd_cyc = tb_cyc;
            checks++;
            if (tb_cyc % PER != 0) begin
                errors++;
                $display("FAIL update_phase: update at cycle %0d phase %0d, required phase 0",
                         tb_cyc, tb_cyc % PER);
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: duty_update with duty %0d at cycle %0d, none expected",
                         duty_cycle, tb_cyc);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (duty_cycle !== e.duty) begin
                    errors++;
                    $display("FAIL update_value: duty %0d at cycle %0d, required %0d",
                             duty_cycle, tb_cyc, e.duty);
                end
                checks++;
                if (tb_cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL update_cycle: update at cycle %0d, required cycle %0d",
                             tb_cyc, e.cyc);
                end
            end
            last_duty = duty_cycle;
        end else begin
            checks++;
            if (duty_cycle !== last_duty || duty_update !== 1'b0) begin
                errors++;
                $display("FAIL duty_stable: duty %0d upd %b at cycle %0d, required duty %0d upd 0",
                         duty_cycle, duty_update, tb_cyc, last_duty);
            end
        end
    end

    function automatic int next_commit(input int pend_edge);
        return (pend_edge / PER + 1) * PER;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_to(input int c);
        for (int i = 0; i < 1000 && tb_cyc < c; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        sb_q.delete();
        model_level = DUTY_MIN;
        reset = 1'b0;
    endtask

    // Drives one press from the current negedge; the raw level is sampled at the next edge.
    task automatic press(input logic up, input logic down, input int high, input int low);
        int         pend_edge;
        logic [1:0] nxt;
        pend_edge = tb_cyc + 1 + 2 + DEB;
        nxt = model_level;
        if (up && !down && nxt != DUTY_MAX)      nxt = nxt + 2'd1;
        else if (down && !up && nxt != DUTY_MIN) nxt = nxt - 2'd1;
        if (nxt != model_level) begin
            sb_q.push_back('{nxt, next_commit(pend_edge)});
            model_level = nxt;
        end
        btn_up   = up;
        btn_down = down;
        idle(high);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        idle(low);
    endtask

    task automatic expect_drained(input string name, input int upd_start, input int upd_exp,
                                  input logic [1:0] duty_exp);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d expected updates never seen", name, sb_q.size());
            sb_q.delete();
        end
        checks++;
        if (upd_count - upd_start != upd_exp) begin
            errors++;
            $display("FAIL %s_update_count: %0d pulses, required %0d",
                     name, upd_count - upd_start, upd_exp);
        end
        checks++;
        if (duty_cycle !== duty_exp) begin
            errors++;
            $display("FAIL %s_final_duty: duty %0d, required %0d", name, duty_cycle, duty_exp);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (duty_cycle !== 2'd0 || duty_update !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: duty %0d upd %b, required 0 0", duty_cycle, duty_update);
        end
        do_reset();
        for (int i = 0; i < 20; i++) begin
            idle(1);
            checks++;
            if (duty_cycle !== 2'd0 || duty_update !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d duty %0d upd %b, required 0 0",
                         tb_cyc, duty_cycle, duty_update);
            end
        end
    endtask

    task automatic test_single_press();
        int start;
        do_reset();
        start = upd_count;
        go_to(2);
        press(1'b1, 1'b0, 112, 20);
        checks++;
        if (last_upd_cyc !== 16) begin
            errors++;
            $display("FAIL single_press_cycle: update at cycle %0d, required 16", last_upd_cyc);
        end
        expect_drained("single_press", start, 1, 2'd1);
    endtask

    task automatic test_bounce();
        int start;
        do_reset();
        start = upd_count;
        go_to(2);
        repeat (5) begin
            btn_up = 1'b1;
            idle(2);
            btn_up = 1'b0;
            idle(1);
        end
        idle(30);
        expect_drained("bounce", start, 0, 2'd0);
    endtask

    task automatic test_saturation();
        int start;
        do_reset();
        start = upd_count;
        idle(2);
        repeat (5) press(1'b1, 1'b0, 10, 10);
        idle(20);
        expect_drained("saturation", start, 3, 2'd3);
    endtask

    task automatic test_simultaneous_down();
        int start;
        do_reset();
        idle(2);
        press(1'b1, 1'b0, 10, 10);
        press(1'b1, 1'b0, 10, 10);
        idle(10);
        start = upd_count;
        press(1'b1, 1'b1, 10, 10);
        idle(10);
        expect_drained("simultaneous", start, 0, 2'd2);
        start = upd_count;
        repeat (3) press(1'b0, 1'b1, 10, 10);
        idle(20);
        expect_drained("down", start, 2, 2'd0);
    endtask

    task automatic test_mid_reset();
        int start;
        do_reset();
        idle(2);
        repeat (3) press(1'b1, 1'b0, 10, 10);
        idle(10);
        expect_drained("mid_reset_setup", 0, upd_count, 2'd3);
        btn_down = 1'b1;
        idle(4);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (duty_cycle !== 2'd0 || duty_update !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: duty %0d upd %b, required 0 0", duty_cycle, duty_update);
        end
        sb_q.delete();
        model_level = DUTY_MIN;
        idle(2);
        reset = 1'b0;
        start = upd_count;
        idle(20);
        btn_down = 1'b0;
        idle(10);
        expect_drained("mid_reset_held_down", start, 0, 2'd0);
        start = upd_count;
        press(1'b1, 1'b0, 10, 20);
        expect_drained("mid_reset_up", start, 1, 2'd1);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_saturation();
        test_simultaneous_down();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_duty_cycle_selector
